// File: rtl/vmac_sched_pkg.sv
// Shared constants, state encoding and record layouts
// for the vector MAC job scheduler.
package vmac_sched_pkg;

  localparam logic [15:0] ACC_CTRL   = 16'd0;
  localparam logic [15:0] ACC_STATUS = 16'd1;
  localparam logic [15:0] ACC_LEN    = 16'd2;
  localparam logic [15:0] ACC_KLEN   = 16'd3;
  localparam logic [15:0] ACC_CYC_LO = 16'd4;
  localparam logic [15:0] ACC_SHIFT  = 16'd6;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int CTRL_MODE  = 2;
  localparam int STAT_DONE  = 1;

  localparam logic [3:0] S_STG_LEN  = 4'd0;
  localparam logic [3:0] S_STG_KLEN = 4'd1;
  localparam logic [3:0] S_JOB_PUSH = 4'd2;
  localparam logic [3:0] S_STATUS   = 4'd3;
  localparam logic [3:0] S_CQ_HEAD  = 4'd4;
  localparam logic [3:0] S_CQ_POP   = 4'd5;
  localparam logic [3:0] S_IRQ_EN   = 4'd6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_LEN,
    ST_WR_KLEN,
    ST_WR_SHIFT,
    ST_WR_START,
    ST_POLL_WAIT,
    ST_POLL,
    ST_RD_CYC,
    ST_WR_CLEAR,
    ST_PUSH_CQ
  } state_e;

  typedef struct packed {
    logic [31:0] len;
    logic [31:0] klen;
    logic [5:0]  shift;
    logic        mode;
    logic [7:0]  tag;
  } job_t;

  typedef struct packed {
    logic [7:0]  tag;
    logic        timeout;
    logic [22:0] cycles;
  } cq_t;

  function automatic logic [31:0] ctrl_data(
    input logic mode,
    input logic start,
    input logic clear
  );
    logic [31:0] d;
    d = '0;
    d[CTRL_MODE]  = mode;
    d[CTRL_START] = start;
    d[CTRL_CLEAR] = clear;
    return d;
  endfunction

  function automatic logic [22:0] sat_cycles(
    input logic [31:0] c
  );
    return (|c[31:23]) ? '1 : c[22:0];
  endfunction

endpackage

// File: rtl/vmac_job_sched_fifo.sv
// sync_fifo: show-ahead FIFO, count output, push accepted when full if popped.
// Ports: clk, rst_n, push/din, pop/dout, full, empty, count.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vmac_job_sched.sv
// Job scheduler: WB slave job/completion queues, WB master sequencer, irq.
// Optional poll watchdog under `VMAC_SCHED_TIMEOUT_EN.
module vmac_job_sched
  import vmac_sched_pkg::*;
#(
  parameter int JQ_DEPTH       = 4,
  parameter int CQ_DEPTH       = 4,
  parameter int POLL_GAP       = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_cyc,
  input  logic        s_stb,
  input  logic        s_we,
  input  logic [3:0]  s_adr,
  input  logic [31:0] s_dat_w,
  output logic [31:0] s_dat_r,
  output logic        s_ack,
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_we,
  output logic [15:0] m_adr,
  output logic [3:0]  m_sel,
  output logic [31:0] m_dat_w,
  input  logic [31:0] m_dat_r,
  input  logic        m_ack,
  output logic        irq
);

  localparam int JW  = $bits(job_t);
  localparam int JCW = $clog2(JQ_DEPTH) + 1;
  localparam int CCW = $clog2(CQ_DEPTH) + 1;

  logic [31:0]    stg_len, stg_klen;
  logic           irq_en, ovf;
  state_e         state, state_d;
  job_t           cur, jq_din;
  logic [JW-1:0]  jq_dout;
  logic [31:0]    cq_dout;
  cq_t            cq_din;
  logic [JCW-1:0] jq_cnt;
  logic [CCW-1:0] cq_cnt;
  logic           jq_push, jq_pop, jq_full, jq_empty;
  logic           cq_push, cq_pop, cq_full, cq_empty;
  logic           s_wr;
  logic [22:0]    cyc_q;
  logic           to_q;
  logic [15:0]    gap_cnt;
  logic           a_req, a_we, issue, acc_done;
  logic [15:0]    a_adr;
  logic [31:0]    a_dat;

  assign m_sel = 4'hF;

  assign s_wr    = s_cyc & s_stb & ~s_ack & s_we;
  assign jq_push = s_wr & (s_adr == S_JOB_PUSH);
  assign cq_pop  = s_wr & (s_adr == S_CQ_POP);
  assign jq_pop  = (state == ST_IDLE) & ~jq_empty;

  always_comb begin
    jq_din       = '0;
    jq_din.len   = stg_len;
    jq_din.klen  = stg_klen;
    jq_din.shift = s_dat_w[5:0];
    jq_din.mode  = s_dat_w[8];
    jq_din.tag   = s_dat_w[23:16];
  end

  assign cq_din = '{tag: cur.tag, timeout: to_q, cycles: cyc_q};

  sync_fifo #(.W(JW), .DEPTH(JQ_DEPTH)) u_jq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (jq_push),
    .din   (jq_din),
    .pop   (jq_pop),
    .dout  (jq_dout),
    .full  (jq_full),
    .empty (jq_empty),
    .count (jq_cnt)
  );

  sync_fifo #(.W(32), .DEPTH(CQ_DEPTH)) u_cq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cq_push),
    .din   (cq_din),
    .pop   (cq_pop),
    .dout  (cq_dout),
    .full  (cq_full),
    .empty (cq_empty),
    .count (cq_cnt)
  );

  always_comb begin
    s_dat_r = '0;
    unique case (1'b1)
      (s_adr == S_STG_LEN):  s_dat_r = stg_len;
      (s_adr == S_STG_KLEN): s_dat_r = stg_klen;
      (s_adr == S_STATUS):   s_dat_r = {12'b0, 4'(cq_cnt), 4'b0,
                                        4'(jq_cnt), 4'b0, ovf, jq_full,
                                        ~cq_empty, state != ST_IDLE};
      (s_adr == S_CQ_HEAD):  s_dat_r = cq_empty ? '0 : cq_dout;
      (s_adr == S_IRQ_EN):   s_dat_r = {31'b0, irq_en};
      default:               s_dat_r = '0;
    endcase
  end

`ifdef VMAC_SCHED_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        to_hit;

  assign to_hit = (to_cnt >= 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      to_q   <= 1'b0;
    end else begin
      to_cnt <= (state == ST_POLL || state == ST_POLL_WAIT)
                ? to_cnt + 1'b1 : '0;
      if (jq_pop) to_q <= 1'b0;
      else if (state == ST_POLL_WAIT && to_hit) to_q <= 1'b1;
    end
  end
`else
  assign to_q = 1'b0;
`endif

  assign acc_done = m_cyc & m_ack;
  assign issue    = a_req & ~m_cyc;

  always_comb begin
    state_d = state;
    a_req   = 1'b0;
    a_we    = 1'b0;
    a_adr   = '0;
    a_dat   = '0;
    cq_push = 1'b0;
    unique case (state)
      ST_IDLE: if (!jq_empty) state_d = ST_WR_LEN;
      ST_WR_LEN: begin
        {a_req, a_we, a_adr, a_dat} = {2'b11, ACC_LEN, cur.len};
        if (acc_done) state_d = ST_WR_KLEN;
      end
      ST_WR_KLEN: begin
        {a_req, a_we, a_adr, a_dat} = {2'b11, ACC_KLEN, cur.klen};
        if (acc_done) state_d = ST_WR_SHIFT;
      end
      ST_WR_SHIFT: begin
        {a_req, a_we, a_adr, a_dat} = {2'b11, ACC_SHIFT, 32'(cur.shift)};
        if (acc_done) state_d = ST_WR_START;
      end
      ST_WR_START: begin
        {a_req, a_we, a_adr} = {2'b11, ACC_CTRL};
        a_dat = ctrl_data(cur.mode, 1'b1, 1'b0);
        if (acc_done) state_d = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        if (gap_cnt == 16'(POLL_GAP - 1)) state_d = ST_POLL;
`ifdef VMAC_SCHED_TIMEOUT_EN
        if (to_hit) state_d = ST_WR_CLEAR;
`endif
      end
      ST_POLL: begin
        {a_req, a_adr} = {1'b1, ACC_STATUS};
        if (acc_done)
          state_d = m_dat_r[STAT_DONE] ? ST_RD_CYC : ST_POLL_WAIT;
      end
      ST_RD_CYC: begin
        {a_req, a_adr} = {1'b1, ACC_CYC_LO};
        if (acc_done) state_d = ST_WR_CLEAR;
      end
      ST_WR_CLEAR: begin
        {a_req, a_we, a_adr} = {2'b11, ACC_CTRL};
        a_dat = ctrl_data(cur.mode, 1'b0, 1'b1);
        if (acc_done) state_d = ST_PUSH_CQ;
      end
      ST_PUSH_CQ: begin
        // a same-cycle pop frees the slot, so a full CQ still accepts
        cq_push = 1'b1;
        if (!cq_full || cq_pop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      s_ack    <= 1'b0;
      irq      <= 1'b0;
      irq_en   <= 1'b0;
      ovf      <= 1'b0;
      stg_len  <= '0;
      stg_klen <= '0;
      cur      <= '0;
      cyc_q    <= '0;
      gap_cnt  <= '0;
      m_cyc    <= 1'b0;
      m_stb    <= 1'b0;
      m_we     <= 1'b0;
      m_adr    <= '0;
      m_dat_w  <= '0;
    end else begin
      state <= state_d;
      s_ack <= s_cyc & s_stb & ~s_ack;
      irq   <= irq_en & ~cq_empty;
      if (s_wr && s_adr == S_STG_LEN)  stg_len  <= s_dat_w;
      if (s_wr && s_adr == S_STG_KLEN) stg_klen <= s_dat_w;
      if (s_wr && s_adr == S_IRQ_EN)   irq_en   <= s_dat_w[0];
      if (jq_push && jq_full && !jq_pop) ovf <= 1'b1;
      else if (s_wr && s_adr == S_STATUS && s_dat_w[3]) ovf <= 1'b0;
      if (jq_pop) begin
        cur   <= job_t'(jq_dout);
        cyc_q <= '0;
      end else if (state == ST_RD_CYC && acc_done) begin
        cyc_q <= sat_cycles(m_dat_r);
      end
      gap_cnt <= (state == ST_POLL_WAIT) ? gap_cnt + 1'b1 : '0;
      if (acc_done) begin
        m_cyc <= 1'b0;
        m_stb <= 1'b0;
        m_we  <= 1'b0;
      end else if (issue) begin
        m_cyc   <= 1'b1;
        m_stb   <= 1'b1;
        m_we    <= a_we;
        m_adr   <= a_adr;
        m_dat_w <= a_dat;
      end
    end
  end

endmodule

// File: tb/tb_vmac_job_sched.sv
// Self-checking bench for vmac_job_sched with an accelerator bus model
// and a transaction-level expectation model.
module tb_vmac_job_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
  logic [3:0]  s_adr = '0;
  logic [31:0] s_dat_w = '0;
  logic [31:0] s_dat_r;
  logic        s_ack;
  logic        m_cyc, m_stb, m_we;
  logic [15:0] m_adr;
  logic [3:0]  m_sel;
  logic [31:0] m_dat_w;
  logic [31:0] m_dat_r;
  logic        m_ack;
  logic        irq;

  always #5 clk = ~clk;

  vmac_job_sched #(
    .JQ_DEPTH(4), .CQ_DEPTH(4), .POLL_GAP(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_sel(m_sel), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r),
    .m_ack(m_ack), .irq(irq)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // accelerator model: one wait state per access, done after LEN+1 ticks
  logic        a_ack = 1'b0, a_busy = 1'b0, a_done = 1'b0;
  logic [31:0] a_len = '0, a_klen = '0, a_shift = '0, a_cnt = '0;
  logic [31:0] last_start = '0, last_clear = '0;
  logic        acc_hang = 1'b0;
  logic [31:0] acc_cyc_ovr = '0;

  assign m_ack   = a_ack;
  assign m_dat_r = (m_adr == 16'd1) ? {30'b0, a_done, a_busy} :
                   (m_adr == 16'd4) ? ((acc_cyc_ovr != 0) ? acc_cyc_ovr
                                                          : a_len + 32'd1)
                                    : 32'd0;

  always @(posedge clk) begin
    a_ack <= m_cyc && m_stb && !a_ack;
    if (m_cyc && m_stb && !a_ack && m_we) begin
      case (m_adr)
        16'd0: begin
          if (m_dat_w[0]) begin
            a_busy <= 1'b1; a_done <= 1'b0; a_cnt <= a_len;
            last_start <= m_dat_w;
          end else if (m_dat_w[1]) begin
            a_busy <= 1'b0; a_done <= 1'b0;
            last_clear <= m_dat_w;
          end
        end
        16'd2: a_len <= m_dat_w;
        16'd3: a_klen <= m_dat_w;
        16'd6: a_shift <= m_dat_w;
        default: ;
      endcase
    end else if (a_busy && !acc_hang) begin
      if (a_cnt == 0) begin a_busy <= 1'b0; a_done <= 1'b1; end
      else a_cnt <= a_cnt - 1;
    end
  end

  typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_wr[$];
  logic [31:0] exp_cq[$];

  function automatic logic [31:0] cq_word(input logic [7:0] tag,
                                          input logic to,
                                          input logic [31:0] cyc);
    logic [22:0] c;
    c = (cyc > 32'h007F_FFFF) ? 23'h7F_FFFF : cyc[22:0];
    return {tag, to, c};
  endfunction

  // every accelerator write is checked, in order, against the job model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_sel", {28'b0, m_sel}, 32'hF);
      if (m_cyc && m_stb && m_ack) begin
        if (m_we) begin
          if (exp_wr.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_wr: adr %h dat %h, none expected",
                     m_adr, m_dat_w);
          end else begin
            chk("wr_adr", {16'b0, m_adr}, {16'b0, exp_wr[0].a});
            chk("wr_dat", m_dat_w, exp_wr[0].d);
            void'(exp_wr.pop_front());
          end
        end else begin
          chk("rd_adr", {31'b0, (m_adr == 16'd1 || m_adr == 16'd4)}, 1);
        end
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [3:0] a,
                         input logic [31:0] d, output logic [31:0] r);
    int n;
    @(negedge clk);
    s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_adr = a; s_dat_w = d;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!s_ack && n < 8);
    if (!s_ack) begin
      checks++; failures++;
      $display("FAIL s_ack_timeout: adr %h got no ack, ack required", a);
    end
    r = s_dat_r;
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
  endtask

  task automatic wb_wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, dummy);
  endtask

  task automatic wb_rd(input logic [3:0] a, output logic [31:0] r);
    wb_xfer(1'b0, a, 32'd0, r);
  endtask

  task automatic push_job(input logic [31:0] len, input logic [31:0] klen,
                          input logic [5:0] shift, input logic mode,
                          input logic [7:0] tag, input bit drop,
                          input bit to);
    wb_wr(4'd0, len);
    wb_wr(4'd1, klen);
    if (!drop) begin
      exp_wr.push_back('{16'd2, len});
      exp_wr.push_back('{16'd3, klen});
      exp_wr.push_back('{16'd6, {26'b0, shift}});
      exp_wr.push_back('{16'd0, {29'b0, mode, 2'b01}});
      exp_wr.push_back('{16'd0, {29'b0, mode, 2'b10}});
      if (to) exp_cq.push_back(cq_word(tag, 1'b1, 32'd0));
      else exp_cq.push_back(cq_word(tag, 1'b0,
             (acc_cyc_ovr != 0) ? acc_cyc_ovr : len + 32'd1));
    end
    wb_wr(4'd2, {8'b0, tag, 7'b0, mode, 2'b0, shift});
  endtask

  task automatic wait_status(input logic [31:0] mask,
                             input logic [31:0] want,
                             input int bound, input string name);
    logic [31:0] r;
    for (int i = 0; i < bound; i++) begin
      wb_rd(4'd3, r);
      if ((r & mask) == want) break;
    end
    chk(name, r & mask, want);
  endtask

  task automatic pop_check(input string name);
    logic [31:0] r;
    wb_rd(4'd4, r);
    if (exp_cq.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: got head %h, no entry expected", name, r);
    end else begin
      chk(name, r, exp_cq[0]);
      void'(exp_cq.pop_front());
    end
    wb_wr(4'd5, 32'd0);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: sim time limit reached, finish required");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [31:0] r;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ack", {31'b0, s_ack}, 0);
    chk("rst_m_cyc", {29'b0, m_cyc, m_stb, m_we}, 0);
    chk("rst_m_adr", {16'b0, m_adr}, 0);
    chk("rst_m_dat", m_dat_w, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    #2 rst_n = 1'b1;
    wb_rd(4'd3, r); chk("rst_status", r, 32'h0);
    wb_rd(4'd4, r); chk("rst_cq_head", r, 32'h0);
    wb_rd(4'd0, r); chk("rst_stg_len", r, 32'h0);
    wb_wr(4'd7, 32'hDEAD_BEEF);
    wb_rd(4'd7, r); chk("unmapped_rd", r, 32'h0);

    // dot job
    wb_wr(4'd6, 32'd1);
    push_job(32'd8, 32'd0, 6'd15, 1'b0, 8'h11, 0, 0);
    wait_status(32'h2, 32'h2, 200, "dot_done");
    @(negedge clk); @(negedge clk);
    chk("dot_irq", {31'b0, irq}, 1);
    wb_rd(4'd4, r); chk("dot_head_lit", r, 32'h1100_0009);
    chk("dot_start", last_start, 32'h1);
    chk("dot_clear", last_clear, 32'h2);
    chk("dot_shift", a_shift, 32'd15);
    pop_check("dot_head");
    @(negedge clk); @(negedge clk);
    chk("dot_irq_low", {31'b0, irq}, 0);
    wb_rd(4'd3, r); chk("dot_idle", r, 32'h0);

    // conv job
    push_job(32'd4, 32'd3, 6'd2, 1'b1, 8'h22, 0, 0);
    wait_status(32'h2, 32'h2, 200, "conv_done");
    wb_rd(4'd4, r); chk("conv_head_lit", r, 32'h2200_0005);
    chk("conv_start", last_start, 32'h5);
    chk("conv_clear", last_clear, 32'h6);
    chk("conv_klen", a_klen, 32'd3);
    pop_check("conv_head");

    // cycle count saturation boundary
    acc_cyc_ovr = 32'h0080_0000;
    push_job(32'd1, 32'd0, 6'd0, 1'b0, 8'h33, 0, 0);
    wait_status(32'h2, 32'h2, 200, "sat_done");
    wb_rd(4'd4, r); chk("sat_head_lit", r, 32'h337F_FFFF);
    pop_check("sat_head");
    acc_cyc_ovr = 32'h007F_FFFE;
    push_job(32'd1, 32'd0, 6'd0, 1'b0, 8'h34, 0, 0);
    wait_status(32'h2, 32'h2, 200, "nosat_done");
    wb_rd(4'd4, r); chk("nosat_head_lit", r, 32'h347F_FFFE);
    pop_check("nosat_head");
    acc_cyc_ovr = 32'h0;

    // fill CQ, stall the scheduler, overflow the JQ
    wb_wr(4'd6, 32'd0);
    for (int i = 0; i < 4; i++)
      push_job(32'd2, 32'd1, 6'd0, 1'b0, 8'h40 + 8'(i), 0, 0);
    wait_status(32'hF_0000, 32'h4_0000, 300, "cq_fill");
    push_job(32'd2, 32'd1, 6'd0, 1'b0, 8'h50, 0, 0);
    repeat (150) @(posedge clk);
    wb_rd(4'd3, r); chk("stall_status", r, 32'h0004_0003);
    for (int i = 0; i < 4; i++)
      push_job(32'd2, 32'd1, 6'd0, 1'b0, 8'h60 + 8'(i), 0, 0);
    push_job(32'd2, 32'd1, 6'd0, 1'b0, 8'h70, 1, 0);
    wb_rd(4'd3, r); chk("ovf_status", r, 32'h0004_040F);
    wb_wr(4'd3, 32'h8);
    wb_rd(4'd3, r); chk("ovf_clear", r, 32'h0004_0407);
    pop_check("simul_pop_head");
    wb_rd(4'd3, r); chk("simul_cq_cnt", (r >> 16) & 32'hF, 32'd4);
    for (int k = 0; k < 12 && exp_cq.size() > 0; k++) begin
      wait_status(32'h2, 32'h2, 200, "drain_wait");
      pop_check("drain_head");
    end
    wait_status(32'hF, 32'h0, 100, "drain_idle");
    chk("wr_all_seen", exp_wr.size(), 0);

    // reset while polling
    wb_wr(4'd6, 32'd1);
    push_job(32'd3, 32'd0, 6'd1, 1'b0, 8'h44, 0, 0);
    wait_status(32'h2, 32'h2, 200, "pre_rst_done");
    acc_hang = 1'b1;
    push_job(32'd5, 32'd0, 6'd1, 1'b0, 8'h45, 0, 0);
    n = 0;
    while (!(m_cyc && m_adr == 16'd1) && n < 300) begin
      @(negedge clk); n++;
    end
    chk("reach_poll", {31'b0, m_cyc && m_adr == 16'd1}, 1);
    chk("pre_rst_irq", {31'b0, irq}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_m_cyc", {30'b0, m_cyc, m_stb}, 0);
    chk("rst_mid_irq", {31'b0, irq}, 0);
    exp_wr.delete();
    exp_cq.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wb_rd(4'd3, r); chk("post_rst_status", r, 32'h0);
    wb_rd(4'd4, r); chk("post_rst_head", r, 32'h0);
    wb_rd(4'd6, r); chk("post_rst_irq_en", r, 32'h0);

`ifdef VMAC_SCHED_TIMEOUT_EN
    push_job(32'd2, 32'd0, 6'd0, 1'b0, 8'h55, 0, 1);
    wait_status(32'h2, 32'h2, 300, "to_done");
    wb_rd(4'd4, r); chk("to_head_lit", r, 32'h5580_0000);
    chk("to_clear", last_clear, 32'h2);
    pop_check("to_head");
`endif

    acc_hang = 1'b0;
    push_job(32'd6, 32'd2, 6'd3, 1'b1, 8'h66, 0, 0);
    wait_status(32'h2, 32'h2, 200, "recover_done");
    wb_rd(4'd4, r); chk("recover_head_lit", r, 32'h6600_0007);
    pop_check("recover_head");
    wait_status(32'hF, 32'h0, 100, "final_idle");
    chk("final_wr_seen", exp_wr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
